// File: rtl/sigma_arb_pkg.sv
// Shared constants and the sample conversion helper for the sigma_arb4 accumulator.
package sigma_arb_pkg;

  localparam int NCH   = 4;
  localparam int SMP_W = 8;
  localparam int SUM_W = 12;

  // Sign-magnitude sample to sign-extended two's complement; 8'h80 maps to zero.
  function automatic logic [SUM_W-1:0] sm_to_tc(input logic [SMP_W-1:0] s);
    logic [SUM_W-1:0] mag;
    mag = {{(SUM_W-SMP_W+1){1'b0}}, s[SMP_W-2:0]};
    if (s[SMP_W-1]) begin
      sm_to_tc = {SUM_W{1'b0}} - mag;
    end else begin
      sm_to_tc = mag;
    end
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter; the search starts one past the last winner,
// and the pointer only moves when a grant is issued.
module rr_arb4
  import sigma_arb_pkg::*;
(
  input  logic           clk,
  input  logic           res,
  input  logic [NCH-1:0] elig_i,
  output logic [NCH-1:0] gnt_o,
  output logic [1:0]     idx_o,
  output logic           vld_o
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [1:0] cand_s;
  logic       hit_s;
  logic       vld_s;
  logic [1:0] idx_s;

  // Priority search from ptr+1 around to ptr itself; the first eligible channel wins.
  always_comb begin
    vld_s  = 1'b0;
    idx_s  = 2'd0;
    cand_s = 2'd0;
    hit_s  = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      cand_s = ptr_q + 2'(k);
      hit_s  = !vld_s && elig_i[cand_s];
      idx_s  = hit_s ? cand_s : idx_s;
      vld_s  = vld_s | hit_s;
    end
    ptr_d = vld_s ? idx_s : ptr_q;
  end

  assign vld_o = vld_s;
  assign idx_o = idx_s;
  assign gnt_o = {{(NCH-1){1'b0}}, vld_s} << idx_s;

  // Pointer register; reset value 3 gives channel 0 first priority.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ptr_q <= 2'd3;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sigma_arb4.sv
// Four-channel windowed accumulator: arbitrate one sample per clock, convert it,
// and add it into that channel's running window sum; emit the sum every N_PT samples.
module sigma_arb4
  import sigma_arb_pkg::*;
#(
  parameter int N_PT  = 16,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*SMP_W-1:0] data_in,
  output logic [NCH-1:0]       ack,
  output logic [SUM_W-1:0]     data_out,
  output logic [1:0]           ch_out,
  output logic                 syn_out
);

  logic [NCH-1:0]   elig_s;
  logic [NCH-1:0]   gnt_s;
  logic [1:0]       idx_s;
  logic             vld_s;
  logic [SUM_W-1:0] val_s;
  logic             last_s;

  logic [NCH-1:0]   ack_q,     ack_d;
  logic             stg_vld_q, stg_vld_d;
  logic [1:0]       stg_ch_q,  stg_ch_d;
  logic [SMP_W-1:0] stg_smp_q, stg_smp_d;
  logic [SUM_W-1:0] sum_q [NCH];
  logic [SUM_W-1:0] sum_d [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [SUM_W-1:0] dout_q,    dout_d;
  logic [1:0]       chout_q,   chout_d;
  logic             syn_q,     syn_d;

  // A channel in its ack cycle still shows the sample just taken, so it is masked.
  assign elig_s = req & ~ack_q;

  rr_arb4 u_arb (
    .clk    (clk),
    .res    (res),
    .elig_i (elig_s),
    .gnt_o  (gnt_s),
    .idx_o  (idx_s),
    .vld_o  (vld_s)
  );

  assign val_s  = sm_to_tc(stg_smp_q);
  assign last_s = (cnt_q[stg_ch_q] == CNT_W'(N_PT-1));

  // Next state: capture the winner into the stage, and fold the staged sample into its window.
  always_comb begin
    ack_d     = gnt_s;
    stg_vld_d = vld_s;
    stg_ch_d  = idx_s;
    stg_smp_d = data_in[idx_s*SMP_W +: SMP_W];
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    chout_d   = chout_q;
    syn_d     = 1'b0;
    if (stg_vld_q && last_s) begin
      dout_d          = sum_q[stg_ch_q] + val_s;
      chout_d         = stg_ch_q;
      syn_d           = 1'b1;
      sum_d[stg_ch_q] = {SUM_W{1'b0}};
      cnt_d[stg_ch_q] = {CNT_W{1'b0}};
    end else if (stg_vld_q) begin
      sum_d[stg_ch_q] = sum_q[stg_ch_q] + val_s;
      cnt_d[stg_ch_q] = cnt_q[stg_ch_q] + CNT_W'(1);
    end else begin
      syn_d = 1'b0;
    end
  end

  // State and output registers; reset discards any partial windows.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ack_q     <= {NCH{1'b0}};
      stg_vld_q <= 1'b0;
      stg_ch_q  <= 2'd0;
      stg_smp_q <= {SMP_W{1'b0}};
      dout_q    <= {SUM_W{1'b0}};
      chout_q   <= 2'd0;
      syn_q     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        sum_q[i] <= {SUM_W{1'b0}};
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      ack_q     <= ack_d;
      stg_vld_q <= stg_vld_d;
      stg_ch_q  <= stg_ch_d;
      stg_smp_q <= stg_smp_d;
      dout_q    <= dout_d;
      chout_q   <= chout_d;
      syn_q     <= syn_d;
      for (int i = 0; i < NCH; i++) begin
        sum_q[i] <= sum_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ack      = ack_q;
  assign data_out = dout_q;
  assign ch_out   = chout_q;
  assign syn_out  = syn_q;

endmodule

// File: tb/tb_sigma_arb4.sv
// Directed bench for sigma_arb4 with a per-cycle behavioural model and literal spot checks.
module tb_sigma_arb4;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] data_in = 32'h0;
  logic [3:0]  ack;
  logic [11:0] data_out;
  logic [1:0]  ch_out;
  logic        syn_out;

  sigma_arb4 #(.N_PT(16), .CNT_W(4)) dut (
    .clk      (clk),
    .res      (res),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .data_out (data_out),
    .ch_out   (ch_out),
    .syn_out  (syn_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Behavioural model state: integers and plain arrays
  int          m_ptr;
  logic [3:0]  m_ack;
  bit          p_vld;
  int          p_ch;
  logic [7:0]  p_smp;
  int          m_sum [4];
  int          m_cnt [4];
  int          m_acks [4] = '{0, 0, 0, 0};
  logic [11:0] m_dout;
  logic [1:0]  m_ch;
  logic        m_syn;
  logic [3:0]  prev_ack = 4'b0000;

  int log_cyc [$];
  int log_ch  [$];
  int log_dat [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int sm_val(input logic [7:0] s);
    int v;
    v = int'(s[6:0]);
    return s[7] ? -v : v;
  endfunction

  task automatic model_reset();
    m_ptr  = 3;
    m_ack  = 4'b0000;
    p_vld  = 1'b0;
    p_ch   = 0;
    p_smp  = 8'h00;
    m_dout = 12'h000;
    m_ch   = 2'd0;
    m_syn  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_sum[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic model_update();
    int v;
    int c;
    int win;
    m_syn = 1'b0;
    if (p_vld) begin
      v = sm_val(p_smp);
      if (m_cnt[p_ch] == 15) begin
        m_dout = 12'(m_sum[p_ch] + v);
        m_ch   = 2'(p_ch);
        m_syn  = 1'b1;
        m_sum[p_ch] = 0;
        m_cnt[p_ch] = 0;
      end else begin
        m_sum[p_ch] = m_sum[p_ch] + v;
        m_cnt[p_ch] = m_cnt[p_ch] + 1;
      end
    end
    win = -1;
    for (int k = 1; k <= 4; k++) begin
      c = (m_ptr + k) % 4;
      if (win < 0 && req[c] && !m_ack[c]) win = c;
    end
    m_ack = 4'b0000;
    p_vld = 1'b0;
    if (win >= 0) begin
      m_ack[win] = 1'b1;
      m_ptr      = win;
      p_vld      = 1'b1;
      p_ch       = win;
      p_smp      = data_in[8*win +: 8];
      m_acks[win] = m_acks[win] + 1;
    end
  endtask

  task automatic compare_all();
    chk("ack", {28'h0, ack}, {28'h0, m_ack});
    chk("syn_out", {31'h0, syn_out}, {31'h0, m_syn});
    chk("data_out", {20'h0, data_out}, {20'h0, m_dout});
    chk("ch_out", {30'h0, ch_out}, {30'h0, m_ch});
    chk("ack_back_to_back", {28'h0, ack & prev_ack}, 32'h0);
    prev_ack = ack;
    if (syn_out === 1'b1) begin
      log_cyc.push_back(cyc);
      log_ch.push_back(int'(ch_out));
      log_dat.push_back(int'(data_out));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (res) model_update();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic do_reset(input int n);
    res = 1'b0;
    model_reset();
    repeat (n) begin
      @(negedge clk);
      cyc++;
      compare_all();
    end
    chk("rst_ack", {28'h0, ack}, 32'h0);
    chk("rst_syn", {31'h0, syn_out}, 32'h0);
    chk("rst_data_out", {20'h0, data_out}, 32'h0);
    chk("rst_ch_out", {30'h0, ch_out}, 32'h0);
    res = 1'b1;
  endtask

  // One channel alone for 16 samples, then pin the result and the syn timing with literals.
  task automatic run_window(input int ch, input logic [7:0] smp, input logic [11:0] exp_sum);
    int start;
    int n;
    req = 4'b0000;
    data_in = 32'h0;
    data_in[8*ch +: 8] = smp;
    req[ch] = 1'b1;
    start = m_acks[ch];
    n = 0;
    while ((m_acks[ch] - start) < 16 && n < 200) begin
      tick();
      n++;
    end
    chk("window_ack_count", 32'(m_acks[ch] - start), 32'd16);
    req = 4'b0000;
    tick();
    chk("win_syn_hi", {31'h0, syn_out}, 32'h1);
    chk("win_data_out", {20'h0, data_out}, {20'h0, exp_sum});
    chk("win_ch_out", {30'h0, ch_out}, 32'(ch));
    chk("model_pin_sum", {20'h0, m_dout}, {20'h0, exp_sum});
    tick();
    chk("win_syn_lo", {31'h0, syn_out}, 32'h0);
    chk("win_data_hold", {20'h0, data_out}, {20'h0, exp_sum});
  endtask

  initial begin
    int n;
    int start;
    int base;
    logic [3:0] exp_alt;

    model_reset();
    #1;
    do_reset(3);

    run_window(0, 8'h01, 12'h010);
    run_window(1, 8'h81, 12'hFF0);
    run_window(2, 8'h80, 12'h000);
    run_window(3, 8'h7F, 12'h7F0);
    run_window(3, 8'hFF, 12'h810);

    // All four channels contending: one grant per cycle, completions on consecutive cycles
    log_cyc.delete();
    log_ch.delete();
    log_dat.delete();
    data_in = {8'h04, 8'h03, 8'h02, 8'h01};
    req = 4'b1111;
    tick();
    chk("rr_first_ack", {28'h0, ack}, 32'h1);
    tick();
    chk("rr_second_ack", {28'h0, ack}, 32'h2);
    repeat (62) tick();
    req = 4'b0000;
    repeat (4) tick();
    chk("rr_syn_count", 32'(log_ch.size()), 32'd4);
    if (log_ch.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("rr_syn_ch", 32'(log_ch[k]), 32'(k));
        chk("rr_syn_data", 32'(log_dat[k]), 32'(16 * (k + 1)));
        chk("rr_syn_consec", 32'(log_cyc[k] - log_cyc[0]), 32'(k));
      end
    end

    // ch0/ch2 with idle gaps: pointer holds, so grants alternate
    data_in = {8'h00, 8'h84, 8'h00, 8'h03};
    exp_alt = 4'b0001;
    for (int r = 0; r < 4; r++) begin
      req = 4'b0101;
      tick();
      chk("alt_ack", {28'h0, ack}, {28'h0, exp_alt});
      req = 4'b0000;
      tick();
      tick();
      chk("alt_gap_ack", {28'h0, ack}, 32'h0);
      exp_alt = (exp_alt == 4'b0001) ? 4'b0100 : 4'b0001;
    end

    // Partial ch2 window discarded by reset
    req = 4'b0100;
    data_in = 32'h0;
    data_in[23:16] = 8'h05;
    start = m_acks[2];
    n = 0;
    while ((m_acks[2] - start) < 10 && n < 100) begin
      tick();
      n++;
    end
    chk("partial_ack_count", 32'(m_acks[2] - start), 32'd10);
    req = 4'b0000;
    base = log_ch.size();
    do_reset(3);
    tick();
    tick();
    chk("no_syn_after_reset", 32'(log_ch.size()), 32'(base));
    run_window(2, 8'h02, 12'h020);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
